// File: rtl/uart_rx_frame_checker_pkg.sv
// rtl/uart_rx_frame_checker_pkg.sv - RX frame checker state type and sizing constants
`include "uart_config.sv"

package uart_rx_frame_checker_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    localparam int RX_WIDTH = `WIDTH;
    localparam int RX_CNT_W = (RX_WIDTH > 1) ? $clog2(RX_WIDTH) : 1;

endpackage

// File: rtl/uart_rx_frame_checker_if.sv
// rtl/uart_rx_frame_checker_if.sv - bit-strobe input and frame-result output bundle
interface uart_rx_frame_checker_if
    import uart_rx_frame_checker_pkg::*;
#(
    parameter int WIDTH = RX_WIDTH
) ();

    logic             bit_valid_in;
    logic             bit_in;
    logic             busy_out;
    logic [WIDTH-1:0] data_out;
    logic             data_valid_out;
    logic             par_err_out;
    logic             stp_err_out;

    modport master (
        output bit_valid_in, bit_in,
        input  busy_out, data_out, data_valid_out, par_err_out, stp_err_out
    );

    modport slave (
        input  bit_valid_in, bit_in,
        output busy_out, data_out, data_valid_out, par_err_out, stp_err_out
    );

endinterface

// File: rtl/uart_config.sv
// rtl/uart_config.sv - shared UART configuration macros
`ifndef UART_CONFIG_SV
`define UART_CONFIG_SV

`define WIDTH 8
`define EVEN_PARITY_CONFIG 1'b0
`define ODD_PARITY_CONFIG  1'b1

`endif

// File: rtl/uart_rx_frame_checker_parity_check.sv
// rtl/uart_rx_frame_checker_parity_check.sv - combinational received-parity mismatch detector
`include "uart_config.sv"

module rx_parity_check #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             par_type_i,
    input  logic             par_bit_i,
    input  logic             par_en_i,
    output logic             mismatch_o
);

    logic expected;

    assign expected   = (par_type_i == `EVEN_PARITY_CONFIG) ? ^data_i : ~^data_i;
    assign mismatch_o = par_en_i & (par_bit_i != expected);

endmodule

// File: rtl/uart_rx_frame_checker.sv
// rtl/uart_rx_frame_checker.sv - UART RX frame deserializer with parity/stop checking
// Optional RX_ERR_DROP_EN: errored frames update flags only, no valid pulse or data update.
`include "uart_config.sv"

module uart_rx_frame_checker
    import uart_rx_frame_checker_pkg::*;
#(
    parameter int WIDTH = RX_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    par_en_in,
    input  logic                    par_type_in,
    uart_rx_frame_checker_if.slave  rx
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    rx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             par_en_q;
    logic             par_type_q;
    logic             par_err_q;
    logic             par_mismatch;
    logic             valid_q;
    logic             par_err_out_q;
    logic             stp_err_out_q;
    logic             busy;

    rx_parity_check #(.WIDTH(WIDTH)) u_parity_check (
        .data_i     (shift_q),
        .par_type_i (par_type_q),
        .par_bit_i  (rx.bit_in),
        .par_en_i   (par_en_q),
        .mismatch_o (par_mismatch)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rx.bit_valid_in) begin
            case (state_q)
                IDLE:    if (!rx.bit_in) state_d = DATA;
                DATA:    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = par_en_q ? PARITY : STOP;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    // Frame config is captured on the start bit so mid-frame changes cannot corrupt the check.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q       <= '0;
            data_q        <= '0;
            cnt_q         <= '0;
            par_en_q      <= 1'b0;
            par_type_q    <= 1'b0;
            par_err_q     <= 1'b0;
            valid_q       <= 1'b0;
            par_err_out_q <= 1'b0;
            stp_err_out_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (rx.bit_valid_in) begin
                case (state_q)
                    IDLE: begin
                        if (!rx.bit_in) begin
                            par_en_q   <= par_en_in;
                            par_type_q <= par_type_in;
                            shift_q    <= '0;
                            cnt_q      <= '0;
                            par_err_q  <= 1'b0;
                        end
                    end
                    DATA: begin
                        shift_q <= {rx.bit_in, shift_q[WIDTH-1:1]};
                        cnt_q   <= cnt_q + 1'b1;
                    end
                    PARITY: begin
                        par_err_q <= par_mismatch;
                    end
                    STOP: begin
                        par_err_out_q <= par_err_q;
                        stp_err_out_q <= ~rx.bit_in;
`ifdef RX_ERR_DROP_EN
                        if (!par_err_q && rx.bit_in) begin
                            valid_q <= 1'b1;
                            data_q  <= shift_q;
                        end
`else
                        valid_q <= 1'b1;
                        data_q  <= shift_q;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx.busy_out       = busy;
    assign rx.data_out       = data_q;
    assign rx.data_valid_out = valid_q;
    assign rx.par_err_out    = par_err_out_q;
    assign rx.stp_err_out    = stp_err_out_q;

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// tb/tb_uart_rx_frame_checker.sv - directed self-checking bench for uart_rx_frame_checker
`include "uart_config.sv"

module tb_uart_rx_frame_checker;

    logic clk;
    logic reset_n;
    logic par_en;
    logic par_type;
    int   n_checks;
    int   n_fail;

`ifdef RX_ERR_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    uart_rx_frame_checker_if rx_if ();

    uart_rx_frame_checker dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .par_en_in   (par_en),
        .par_type_in (par_type),
        .rx          (rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("%s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic b);
        rx_if.bit_valid_in = 1'b1;
        rx_if.bit_in       = b;
        @(negedge clk);
        rx_if.bit_valid_in = 1'b0;
    endtask

    task automatic gap();
        @(negedge clk);
    endtask

    // Returns right after the stop strobe's edge, when the result pulse is visible.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb,
                              input logic sb, input logic flip);
        strobe(1'b0);
        gap();
        if (flip) par_type = ~par_type;
        for (int i = 0; i < 8; i++) begin
            strobe(d[i]);
            gap();
        end
        if (pe) begin
            strobe(pb);
            gap();
        end
        strobe(sb);
    endtask

    initial begin
        n_checks           = 0;
        n_fail             = 0;
        reset_n            = 1'b0;
        par_en             = 1'b1;
        par_type           = `EVEN_PARITY_CONFIG;
        rx_if.bit_valid_in = 1'b0;
        rx_if.bit_in       = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(rx_if.busy_out), 32'h0);
        check("rst_data", 32'(rx_if.data_out), 32'h0);
        check("rst_valid", 32'(rx_if.data_valid_out), 32'h0);
        check("rst_perr", 32'(rx_if.par_err_out), 32'h0);
        check("rst_serr", 32'(rx_if.stp_err_out), 32'h0);
        reset_n = 1'b1;
        gap();

        // even parity, clean frame
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
        check("t1_valid", 32'(rx_if.data_valid_out), 32'h1);
        check("t1_data", 32'(rx_if.data_out), 32'h5A);
        check("t1_perr", 32'(rx_if.par_err_out), 32'h0);
        check("t1_serr", 32'(rx_if.stp_err_out), 32'h0);
        check("t1_busy", 32'(rx_if.busy_out), 32'h0);
        gap();
        check("t1_pulse_end", 32'(rx_if.data_valid_out), 32'h0);
        check("t1_data_hold", 32'(rx_if.data_out), 32'h5A);

        // wrong parity bit
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t2_perr", 32'(rx_if.par_err_out), 32'h1);
        check("t2_serr", 32'(rx_if.stp_err_out), 32'h0);
        check("t2_valid", 32'(rx_if.data_valid_out), DROP ? 32'h0 : 32'h1);
        check("t2_data", 32'(rx_if.data_out), 32'h5A);
        gap();
        check("t2_perr_hold", 32'(rx_if.par_err_out), 32'h1);
        check("t2_valid_low", 32'(rx_if.data_valid_out), 32'h0);

        // no parity, break on stop bit
        par_en = 1'b0;
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t3_serr", 32'(rx_if.stp_err_out), 32'h1);
        check("t3_perr", 32'(rx_if.par_err_out), 32'h0);
        check("t3_valid", 32'(rx_if.data_valid_out), DROP ? 32'h0 : 32'h1);
        check("t3_data", 32'(rx_if.data_out), DROP ? 32'h5A : 32'hFF);
        check("t3_busy", 32'(rx_if.busy_out), 32'h0);
        gap();

        // odd parity, then config toggled mid-frame
        par_en   = 1'b1;
        par_type = `ODD_PARITY_CONFIG;
        send_frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t4_valid", 32'(rx_if.data_valid_out), 32'h1);
        check("t4_data", 32'(rx_if.data_out), 32'h00);
        check("t4_perr", 32'(rx_if.par_err_out), 32'h0);
        check("t4_serr", 32'(rx_if.stp_err_out), 32'h0);
        gap();
        send_frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
        check("t4_latch_valid", 32'(rx_if.data_valid_out), 32'h1);
        check("t4_latch_perr", 32'(rx_if.par_err_out), 32'h0);
        gap();

        // reset mid-frame, then a clean frame
        par_en   = 1'b0;
        par_type = `EVEN_PARITY_CONFIG;
        strobe(1'b0);
        gap();
        for (int i = 0; i < 4; i++) begin
            strobe(1'b1);
            gap();
        end
        check("t5_busy_mid", 32'(rx_if.busy_out), 32'h1);
        #1 reset_n = 1'b0;
        #1;
        check("t5_busy_rst", 32'(rx_if.busy_out), 32'h0);
        check("t5_data_rst", 32'(rx_if.data_out), 32'h0);
        check("t5_valid_rst", 32'(rx_if.data_valid_out), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        gap();
        send_frame(8'hA3, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_valid", 32'(rx_if.data_valid_out), 32'h1);
        check("t5_data", 32'(rx_if.data_out), 32'hA3);
        check("t5_perr", 32'(rx_if.par_err_out), 32'h0);
        check("t5_serr", 32'(rx_if.stp_err_out), 32'h0);
        gap();

        // back-to-back frames, then idle strobes
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t6_valid_a", 32'(rx_if.data_valid_out), 32'h1);
        check("t6_data_a", 32'(rx_if.data_out), 32'h12);
        gap();
        send_frame(8'h34, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t6_valid_b", 32'(rx_if.data_valid_out), 32'h1);
        check("t6_data_b", 32'(rx_if.data_out), 32'h34);
        gap();
        for (int i = 0; i < 3; i++) begin
            strobe(1'b1);
            check("t6_idle_busy", 32'(rx_if.busy_out), 32'h0);
            check("t6_idle_valid", 32'(rx_if.data_valid_out), 32'h0);
            gap();
        end
        check("t6_data_hold", 32'(rx_if.data_out), 32'h34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
